// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises ps2clk/ps2data, deframes 11-bit frames and
// queues good scancodes in a FIFO behind a registered status/data word.
// Define PS2_BREAK_FILTER_EN to swallow 0xF0 break prefixes and the byte after them.
module ps2_rx_fifo #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 20000,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2clk,
    input  logic        ps2data,
    input  logic        rd,
    input  logic        clr,
    output logic [31:0] out,
    output logic        irq
);

    localparam int PW   = $clog2(DEPTH);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    state_t    state, state_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic [7:0] shreg, shreg_n;
    logic       par, par_n;
    logic [TO_W-1:0] tcnt, tcnt_n;
    logic       frame_ok;
    logic       frame_err;
    logic       keep;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [4:0]    count;
    logic          ovf;
    logic          err;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          ovf_set;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Sync flops clear to 0 so reset release can never fabricate a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            par    <= 1'b0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            par    <= par_n;
            tcnt   <= tcnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        par_n     = par;
        tcnt_n    = '0;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        if (state != S_IDLE) tcnt_n = fall ? '0 : tcnt + 1'b1;
        case (state)
            S_IDLE: begin
                if (fall && !data_s) begin
                    state_n  = S_DATA;
                    bitcnt_n = '0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shreg_n  = {data_s, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_n   = data_s;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_n = S_IDLE;
                    if (data_s && (^{shreg, par})) frame_ok = 1'b1;
                    else frame_err = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Line went quiet mid-frame: abandon the partial byte.
        if (state != S_IDLE && !fall && tcnt == TO_W'(TIMEOUT - 1)) begin
            state_n   = S_IDLE;
            tcnt_n    = '0;
            frame_err = 1'b1;
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    logic drop, drop_n;

    always_comb begin
        keep   = 1'b0;
        drop_n = drop;
        if (frame_err) begin
            drop_n = 1'b0;
        end else if (frame_ok) begin
            if (drop) drop_n = 1'b0;
            else if (shreg == 8'hF0) drop_n = 1'b1;
            else keep = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop <= 1'b0;
        else      drop <= drop_n;
    end
`else
    assign keep = frame_ok;
`endif

    assign empty   = (count == 5'd0);
    assign full    = (count == 5'(DEPTH));
    assign pop     = rd && !empty;
    assign push_ok = keep && (!full || pop);
    assign ovf_set = keep && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            err   <= 1'b0;
            irq   <= 1'b0;
            out   <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= shreg;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + {4'd0, push_ok} - {4'd0, pop};
            // A set event in the same cycle as clr wins.
            if (ovf_set)   ovf <= 1'b1;
            else if (clr)  ovf <= 1'b0;
            if (frame_err) err <= 1'b1;
            else if (clr)  err <= 1'b0;
            irq <= push_ok;
            out <= {!empty, ovf, err, count, 16'h0000, empty ? 8'h00 : mem[rptr]};
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: bit-bangs PS/2 frames and compares the status
// word and irq pulse count against a queue-based model of the receiver.
module tb_ps2_rx_fifo;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 300;
    localparam int SYNC    = 2;
    localparam int HALF    = 8;

    logic        clk;
    logic        rst;
    logic        ps2clk;
    logic        ps2data;
    logic        rd;
    logic        clr;
    logic [31:0] out;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    int irq_cnt = 0;
    int exp_irq = 0;

    logic [7:0] exp_q[$];
    bit m_ovf;
    bit m_err;
    bit m_drop;

    ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .ps2clk(ps2clk), .ps2data(ps2data),
        .rd(rd), .clr(clr), .out(out), .irq(irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rst === 1'b1 && irq === 1'b1) irq_cnt++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required finish before 5ms");
        $fatal(1, "watchdog");
    end

    // model
    function automatic logic [31:0] exp_word();
        logic [7:0] h;
        h = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        return {exp_q.size() != 0, m_ovf, m_err, 5'(exp_q.size()), 16'h0000, h};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_err  = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_err  = 1'b1;
            m_drop = 1'b0;
            return;
        end
`ifdef PS2_BREAK_FILTER_EN
        if (m_drop) begin
            m_drop = 1'b0;
            return;
        end
        if (b == 8'hF0) begin
            m_drop = 1'b1;
            return;
        end
`endif
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(b);
            exp_irq++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_pop();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    // drivers
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; ps2clk = 1'b1; ps2data = 1'b1; rd = 1'b0; clr = 1'b0;
        wait_cycles(5);
        rst = 1'b1;
        wait_cycles(5);
        model_reset();
    endtask

    task automatic drive_bit(input logic v);
        ps2data = v;
        wait_cycles(HALF);
        ps2clk = 1'b0;
        wait_cycles(HALF);
        ps2clk = 1'b1;
    endtask

    // rd_at_stop raises rd exactly in the cycle the stop-bit edge is detected.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit rd_at_stop);
        logic p;
        p = ~^b;
        if (bad_par) p = ~p;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(p);
        ps2data = ~bad_stop;
        wait_cycles(HALF);
        ps2clk = 1'b0;
        if (rd_at_stop) begin
            wait_cycles(SYNC);
            rd = 1'b1;
            wait_cycles(1);
            rd = 1'b0;
            wait_cycles(HALF - SYNC - 1);
        end else begin
            wait_cycles(HALF);
        end
        ps2clk = 1'b1;
        wait_cycles(HALF);
        ps2data = 1'b1;
        wait_cycles(4);
        if (rd_at_stop) model_pop();
        model_frame(b, !bad_par && !bad_stop);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        wait_cycles(1);
        rd = 1'b0;
        wait_cycles(3);
        model_pop();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        wait_cycles(1);
        clr = 1'b0;
        wait_cycles(3);
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    // tests
    task automatic test_reset();
        int base;
        do_reset();
        base = irq_cnt;
        wait_cycles(50);
        n_cmp++;
        if (out !== 32'h0000_0000) begin
            n_err++; $display("FAIL reset_out: got %h expected %h", out, 32'h0);
        end
        n_cmp++;
        if (irq_cnt - base != 0) begin
            n_err++; $display("FAIL reset_irq: got %0d pulses expected 0", irq_cnt - base);
        end
    endtask

    task automatic test_single();
        int base;
        do_reset();
        base = irq_cnt;
        send_frame(8'h1C, 0, 0, 0);
        n_cmp++;
        if (out !== 32'h8100_001C) begin
            n_err++; $display("FAIL single_out: got %h expected %h", out, 32'h8100001C);
        end
        n_cmp++;
        if (irq_cnt - base != 1) begin
            n_err++; $display("FAIL single_irq: got %0d pulses expected 1", irq_cnt - base);
        end
        pulse_rd();
        n_cmp++;
        if (out !== 32'h0000_0000) begin
            n_err++; $display("FAIL single_pop: got %h expected %h", out, 32'h0);
        end
        pulse_rd();
        n_cmp++;
        if (out !== 32'h0000_0000) begin
            n_err++; $display("FAIL empty_rd: got %h expected %h", out, 32'h0);
        end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        base = irq_cnt;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
        n_cmp++;
        if (out !== 32'hC800_0001) begin
            n_err++; $display("FAIL ovf_out: got %h expected %h", out, 32'hC8000001);
        end
        n_cmp++;
        if (irq_cnt - base != 8) begin
            n_err++; $display("FAIL ovf_irq: got %0d pulses expected 8", irq_cnt - base);
        end
        pulse_clr();
        n_cmp++;
        if (out !== 32'h8800_0001) begin
            n_err++; $display("FAIL ovf_clr: got %h expected %h", out, 32'h88000001);
        end
        for (int i = 0; i < DEPTH; i++) begin
            pulse_rd();
            n_cmp++;
            if (out !== exp_word()) begin
                n_err++; $display("FAIL drain_%0d: got %h expected %h", i, out, exp_word());
            end
        end
    endtask

    task automatic test_errors();
        int base;
        do_reset();
        base = irq_cnt;
        send_frame(8'h1C, 1, 0, 0);
        n_cmp++;
        if (out !== 32'h2000_0000) begin
            n_err++; $display("FAIL parity_err: got %h expected %h", out, 32'h20000000);
        end
        pulse_clr();
        // start bit plus four data bits, then silence
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(i & 1));
        ps2data = 1'b1;
        wait_cycles(TIMEOUT + 20);
        model_frame(8'h00, 0);
        n_cmp++;
        if (out !== 32'h2000_0000) begin
            n_err++; $display("FAIL timeout_err: got %h expected %h", out, 32'h20000000);
        end
        n_cmp++;
        if (irq_cnt - base != 0) begin
            n_err++; $display("FAIL err_irq: got %0d pulses expected 0", irq_cnt - base);
        end
        send_frame(8'h32, 0, 0, 0);
        n_cmp++;
        if (out !== 32'hA100_0032) begin
            n_err++; $display("FAIL after_err: got %h expected %h", out, 32'hA1000032);
        end
        send_frame(8'h55, 0, 1, 0);
        pulse_clr();
        n_cmp++;
        if (out !== 32'h8100_0032) begin
            n_err++; $display("FAIL stop_err_clr: got %h expected %h", out, 32'h81000032);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_frame(8'h40 + 8'(i), 0, 0, 0);
        base = irq_cnt;
        send_frame(8'h48, 0, 0, 1);
        n_cmp++;
        if (out !== 32'h8800_0041) begin
            n_err++; $display("FAIL full_push_pop: got %h expected %h", out, 32'h88000041);
        end
        n_cmp++;
        if (irq_cnt - base != 1) begin
            n_err++; $display("FAIL full_push_pop_irq: got %0d pulses expected 1", irq_cnt - base);
        end
        for (int i = 0; i < DEPTH; i++) begin
            pulse_rd();
            n_cmp++;
            if (out !== exp_word()) begin
                n_err++; $display("FAIL b2b_drain_%0d: got %h expected %h", i, out, exp_word());
            end
        end
    endtask

    task automatic test_break_filter();
        int base;
        do_reset();
        base = irq_cnt;
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
`ifdef PS2_BREAK_FILTER_EN
        n_cmp++;
        if (out !== 32'h8100_001C || irq_cnt - base != 1) begin
            n_err++; $display("FAIL break_filter: got %h/%0d expected %h/1", out, irq_cnt - base, 32'h8100001C);
        end
`else
        n_cmp++;
        if (out !== 32'h8300_00F0 || irq_cnt - base != 3) begin
            n_err++; $display("FAIL break_passthru: got %h/%0d expected %h/3", out, irq_cnt - base, 32'h830000F0);
        end
`endif
        while (exp_q.size() != 0) begin
            pulse_rd();
            n_cmp++;
            if (out !== exp_word()) begin
                n_err++; $display("FAIL break_drain: got %h expected %h", out, exp_word());
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int sel;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            b   = ($urandom_range(0, 7) == 0) ? 8'hF0 : 8'($urandom_range(0, 255));
            sel = $urandom_range(0, 9);
            send_frame(b, sel == 0, sel == 1, 0);
            if ($urandom_range(0, 1) == 1) pulse_rd();
            if ($urandom_range(0, 5) == 0) pulse_clr();
            n_cmp++;
            if (out !== exp_word()) begin
                n_err++; $display("FAIL rand_%0d: got %h expected %h", it, out, exp_word());
            end
        end
        n_cmp++;
        if (irq_cnt !== exp_irq) begin
            n_err++; $display("FAIL rand_irq: got %0d pulses expected %0d", irq_cnt, exp_irq);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_frame(8'h11, 0, 0, 0);
        send_frame(8'h22, 0, 0, 0);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        ps2data = 1'b0;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(2);
        n_cmp++;
        if (out !== 32'h0000_0000 || irq !== 1'b0) begin
            n_err++; $display("FAIL in_reset: got %h irq %b expected %h irq 0", out, irq, 32'h0);
        end
        ps2clk = 1'b1;
        ps2data = 1'b1;
        rst = 1'b1;
        model_reset();
        wait_cycles(20);
        n_cmp++;
        if (out !== 32'h0000_0000) begin
            n_err++; $display("FAIL after_reset: got %h expected %h", out, 32'h0);
        end
        send_frame(8'h5A, 0, 0, 0);
        n_cmp++;
        if (out !== 32'h8100_005A) begin
            n_err++; $display("FAIL reset_resume: got %h expected %h", out, 32'h8100005A);
        end
    endtask

    initial begin
        rst = 1'b0; ps2clk = 1'b1; ps2data = 1'b1; rd = 1'b0; clr = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_overflow();
        test_errors();
        test_back_to_back();
        test_break_filter();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
